key_debouncer: RTL

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_debouncer_pkg.sv | 23 ++
 rtl/key_debounce_lane.sv | 136 +++++++++++++
 rtl/key_debouncer.sv | 46 ++++
 3 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared constants and helpers for the pushbutton debouncer.
// Holds the default lane count, default timing constants, the counter-width
// helper and the auto-repeat phase type used when KEY_DEBOUNCER_AUTOREPEAT_EN
// is defined.
package key_debouncer_pkg;

  localparam int unsigned DEFAULT_NUM_KEYS        = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_HOLD_DELAY      = 25000000;  // 500 ms at 50 MHz
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

  // Auto-repeat phase: waiting for the first repeat, or repeating periodically
  typedef enum logic {
    RPT_HOLD   = 1'b0,
    RPT_REPEAT = 1'b1
  } rpt_phase_e;

  // Bits needed to hold any value in 0..max_count (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One pushbutton lane: 2-flop synchronizer, stable-level counter, registered
// debounced level and one-cycle press/release strobes.
// Optional auto-repeat of the press strobe when KEY_DEBOUNCER_AUTOREPEAT_EN
// is defined; without it no repeat timer exists.
module key_debounce_lane
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_DELAY      = DEFAULT_HOLD_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_i,
  output logic key_clean_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  // The edge on which the counter would reach DEBOUNCE_CYCLES is the accept edge
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_LVL = RAW_ACTIVE_LOW;
  localparam logic             PRESS_LVL = ~RAW_ACTIVE_LOW;

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;
  logic             clean_dly_q;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             rpt_fire;

  // Two-flop synchronizer; resets to the idle level so nothing looks pressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count cycles the synchronized level disagrees with the clean level; accept on the last one
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state: counter, clean level and its one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      clean_q     <= IDLE_LVL;
      clean_dly_q <= IDLE_LVL;
    end else begin
      cnt_q       <= cnt_d;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int unsigned      RPT_MAX   = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned      RPT_W     = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_DELAY - 1);
  localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  rpt_phase_e       rpt_phase_q;
  logic             rpt_run;

  // Timer runs only after the initial press strobe and while the key stays pressed
  assign rpt_run  = (clean_q == PRESS_LVL) && (clean_dly_q == PRESS_LVL);
  assign rpt_fire = rpt_run &&
                    ((rpt_phase_q == RPT_HOLD) ? (rpt_cnt_q == HOLD_LAST)
                                               : (rpt_cnt_q == REP_LAST));

  // Repeat FSM: long hold delay first, then the shorter repeat period until release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= RPT_HOLD;
    end else if (!rpt_run) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= RPT_HOLD;
    end else if (rpt_fire) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= RPT_REPEAT;
    end else begin
      rpt_cnt_q   <= rpt_cnt_q + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Strobe decode from the clean level moving between idle and pressed
  always_comb begin
    press_d   = ((clean_q == PRESS_LVL) && (clean_dly_q != PRESS_LVL)) || rpt_fire;
    release_d = (clean_q == IDLE_LVL) && (clean_dly_q != IDLE_LVL);
  end

  // Registered strobes so no path exists from the raw input to any output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_clean_o     = clean_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key pushbutton debouncer: NUM_KEYS independent lanes, each with its
// own synchronizer, stable-level counter and press/release strobes.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press strobes while a
// key is held (HOLD_DELAY, then every REPEAT_PERIOD cycles).
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_DELAY      = DEFAULT_HOLD_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_clean,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  // Zero-length timings would make the compare constants underflow
  if (DEBOUNCE_CYCLES < 1 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debouncer: DEBOUNCE_CYCLES, HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
      ,
      .HOLD_DELAY      (HOLD_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_lane (
      .clk             (clk),
      .reset           (reset),
      .key_raw_i       (keys_raw[gi]),
      .key_clean_o     (keys_clean[gi]),
      .press_pulse_o   (press_pulse[gi]),
      .release_pulse_o (release_pulse[gi])
    );
  end

endmodule
